// File: rtl/ser_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ser_tx
//  Brief    : Parallel-to-serial frame transmitter. Sends a DATA_W-bit word
//             LSB-first between a start bit (0) and a stop bit (1), each bit
//             held for CLKS_PER_BIT clocks. tx comes straight from a flop.
//  Options  : `define SER_TX_PARITY_EN inserts an even-parity bit between the
//             last data bit and the stop bit.
//  Revision : 1.0  initial release
// ============================================================================
module ser_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              load,
   output logic              ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int c_bit_w  = $clog2(DATA_W + 1);

   localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
   localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_W - 1);

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_start  = 3'd1;
   localparam logic [2:0] c_st_data   = 3'd2;
   localparam logic [2:0] c_st_stop   = 3'd3;
`ifdef SER_TX_PARITY_EN
   localparam logic [2:0] c_st_parity = 3'd4;
`endif

   logic [2:0]          r_state, w_state_nxt;
   logic [DATA_W-1:0]   r_shift, w_shift_nxt;
   logic [c_baud_w-1:0] r_baud,  w_baud_nxt;
   logic [c_bit_w-1:0]  r_bit,   w_bit_nxt;
   logic                r_tx,    w_tx_nxt;
   logic                r_done,  w_done_nxt;
   logic                w_last_baud;
`ifdef SER_TX_PARITY_EN
   logic                r_par,   w_par_nxt;
`endif

   assign w_last_baud = (r_baud == c_baud_last);

   // State register: FSM, shift register, counters and the registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_st_idle;
         r_shift <= '0;
         r_baud  <= '0;
         r_bit   <= '0;
         r_tx    <= 1'b1;
         r_done  <= 1'b0;
`ifdef SER_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_tx    <= w_tx_nxt;
         r_done  <= w_done_nxt;
`ifdef SER_TX_PARITY_EN
         r_par   <= w_par_nxt;
`endif
      end
   end

   // Next-state logic: advance one bit each time the baud counter wraps.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
`ifdef SER_TX_PARITY_EN
      w_par_nxt   = r_par;
`endif
      case (r_state)
         c_st_idle: begin
            w_baud_nxt = '0;
            w_bit_nxt  = '0;
            if (load) begin
               w_state_nxt = c_st_start;
               w_shift_nxt = din;
`ifdef SER_TX_PARITY_EN
               w_par_nxt   = ^din;
`endif
            end
         end
         c_st_start: begin
            if (w_last_baud) begin
               w_state_nxt = c_st_data;
               w_baud_nxt  = '0;
            end else begin
               w_baud_nxt  = r_baud + c_baud_w'(1);
            end
         end
         c_st_data: begin
            if (w_last_baud) begin
               w_baud_nxt  = '0;
               w_shift_nxt = r_shift >> 1;
               if (r_bit == c_bit_last) begin
                  w_bit_nxt = '0;
`ifdef SER_TX_PARITY_EN
                  w_state_nxt = c_st_parity;
`else
                  w_state_nxt = c_st_stop;
`endif
               end else begin
                  w_bit_nxt = r_bit + c_bit_w'(1);
               end
            end else begin
               w_baud_nxt  = r_baud + c_baud_w'(1);
            end
         end
`ifdef SER_TX_PARITY_EN
         c_st_parity: begin
            if (w_last_baud) begin
               w_state_nxt = c_st_stop;
               w_baud_nxt  = '0;
            end else begin
               w_baud_nxt  = r_baud + c_baud_w'(1);
            end
         end
`endif
         c_st_stop: begin
            if (w_last_baud) begin
               w_state_nxt = c_st_idle;
               w_baud_nxt  = '0;
            end else begin
               w_baud_nxt  = r_baud + c_baud_w'(1);
            end
         end
         default: begin
            w_state_nxt = c_st_idle;
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
         end
      endcase
   end

   // Output logic: tx is precomputed from the next state so the flop shows the
   // new bit on the same edge the state changes; done marks the STOP exit.
   always_comb begin
      w_tx_nxt   = 1'b1;
      w_done_nxt = (r_state == c_st_stop) && w_last_baud;
      case (w_state_nxt)
         c_st_start:  w_tx_nxt = 1'b0;
         c_st_data:   w_tx_nxt = w_shift_nxt[0];
`ifdef SER_TX_PARITY_EN
         c_st_parity: w_tx_nxt = r_par;
`endif
         default:     w_tx_nxt = 1'b1;
      endcase
   end

   assign tx    = r_tx;
   assign done  = r_done;
   assign ready = (r_state == c_st_idle);
   assign busy  = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_ser_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ser_tx
//  Brief    : Scoreboard bench for ser_tx. The driver keeps a frame-level
//             model (a queue of per-cycle line levels built from the word) and
//             pushes the expected outputs for every cycle; a monitor on the
//             falling edge pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ser_tx;

   localparam int DATA_W = 8;
   localparam int CPB    = 4;
`ifdef SER_TX_PARITY_EN
   localparam int NBITS  = DATA_W + 3;
`else
   localparam int NBITS  = DATA_W + 2;
`endif
   localparam int FRAME  = NBITS * CPB;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              load = 1'b0;
   logic [DATA_W-1:0] din = '0;
   logic              ready, tx, busy, done;

   ser_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .din(din), .load(load),
      .ready(ready), .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        tx;
      logic        ready;
      logic        busy;
      logic        done;
      logic [31:0] cyc;
   } exp_t;

   exp_t expq[$];
   logic bitq[$];
   bit   in_frame = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   task automatic check(input string nm, input logic act, input logic exp, input int c);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle %0d: got %b want %b", nm, c, act, exp);
      end
   endtask

   // Line levels of one frame: start, data LSB first, optional parity, stop.
   function automatic void push_frame(input logic [DATA_W-1:0] d);
      logic b;
      for (int i = 0; i < NBITS; i++) begin
         if (i == 0)                b = 1'b0;
         else if (i <= DATA_W)      b = d[i-1];
         else if (i == NBITS - 1)   b = 1'b1;
         else                       b = ^d;
         for (int k = 0; k < CPB; k++) bitq.push_back(b);
      end
   endfunction

   // Drive one cycle and record what the line must look like after the edge.
   // A word offered on the done cycle starts at the following edge.
   task automatic cycle(input logic r, input logic l, input logic [DATA_W-1:0] d);
      exp_t e;
      bit   idle_before;
      rst = r; load = l; din = d;
      @(posedge clk);
      cyc++;
      e = '0;
      if (r) begin
         bitq.delete();
         in_frame = 1'b0;
         e.done   = 1'b0;
      end else begin
         idle_before = !in_frame;
         e.done      = in_frame && (bitq.size() == 0);
         if (idle_before && l) begin
            push_frame(d);
            in_frame = 1'b1;
         end else begin
            in_frame = (bitq.size() != 0);
         end
      end
      e.tx    = in_frame ? bitq.pop_front() : 1'b1;
      e.ready = !in_frame;
      e.busy  = in_frame;
      e.cyc   = cyc;
      expq.push_back(e);
      #1;
   endtask

   // Monitor: compare DUT outputs against the scoreboard away from the edge.
   exp_t m_e;
   always @(negedge clk) begin
      if (expq.size() != 0) begin
         m_e = expq.pop_front();
         check("tx",    tx,    m_e.tx,    int'(m_e.cyc));
         check("ready", ready, m_e.ready, int'(m_e.cyc));
         check("busy",  busy,  m_e.busy,  int'(m_e.cyc));
         check("done",  done,  m_e.done,  int'(m_e.cyc));
      end
   end

   initial begin
      // Reset held with load asserted: nothing may start.
      repeat (3) cycle(1'b1, 1'b1, 8'hFF);
      repeat (2) cycle(1'b0, 1'b0, 8'h00);

      // Single frame; din wiggles after acceptance.
      cycle(1'b0, 1'b1, 8'hA5);
      repeat (FRAME + 3) cycle(1'b0, 1'b0, DATA_W'($urandom));

      // Back-to-back: load held through the first frame.
      cycle(1'b0, 1'b1, 8'h3C);
      repeat (FRAME + 1) cycle(1'b0, 1'b1, 8'hC3);
      repeat (FRAME + 4) cycle(1'b0, 1'b0, 8'h00);

      // Load mid-frame is ignored.
      cycle(1'b0, 1'b1, 8'hFF);
      for (int i = 1; i <= FRAME + 5; i++)
         cycle(1'b0, i == 10, (i == 10) ? 8'h00 : 8'hFF);

      // Reset mid-frame, then a clean frame.
      cycle(1'b0, 1'b1, 8'h55);
      repeat (14) cycle(1'b0, 1'b0, DATA_W'($urandom));
      cycle(1'b1, 1'b0, 8'h00);
      repeat (2) cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h0F);
      repeat (FRAME + 3) cycle(1'b0, 1'b0, 8'h00);

      // Odd-parity word.
      cycle(1'b0, 1'b1, 8'h07);
      repeat (FRAME + 3) cycle(1'b0, 1'b0, 8'h00);

      // Random traffic with occasional resets.
      repeat (600)
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, DATA_W'($urandom));

      repeat (FRAME + 2) cycle(1'b0, 1'b0, 8'h00);
      @(negedge clk);
      #1;
      total++;
      if (expq.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", expq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
